// File: rtl/rpn_axis_type_router.sv
// Packet-aware AXI-Stream router: decodes the RPN message type on the first
// beat, picks the lowest-index channel whose value/mask pair matches, holds
// that route until tlast and presents beats through a one-deep output slice.
// Unmatched packets are either consumed and counted, or sent to a default
// channel.
//
// Handshake: a beat moves on the input when from_network_bridge_tvalid and
// from_network_bridge_tready are both high at a rising clock edge; a beat
// leaves the slice when to_rpn_tvalid[k] and to_rpn_tready[k] are both high
// for the one selected channel k. tready on other channels has no effect, and
// the slice holds tvalid and payload stable until its beat is taken.
module rpn_axis_type_router #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_TDEST_WIDTH = 8,
   parameter int AXIS_TUSER_WIDTH = 64,
   parameter int NUM_CHANNELS     = 4,
   parameter int MSG_TYPE_OFFSET  = 0,
   parameter int MSG_TYPE_WIDTH   = 8,
   parameter logic [NUM_CHANNELS*MSG_TYPE_WIDTH-1:0] CH_MATCH_VALUE = {8'h40, 8'h20, 8'h10, 8'h00},
   parameter logic [NUM_CHANNELS*MSG_TYPE_WIDTH-1:0] CH_MATCH_MASK  = {8'hF0, 8'hE0, 8'hF0, 8'hF0},
   parameter int DROP_UNMATCHED   = 1,
   parameter int DEFAULT_CHANNEL  = 0
) (
   input  logic                        i_clk,
   input  logic                        i_ap_rst_n,
   input  logic                        from_network_bridge_tvalid,
   output logic                        from_network_bridge_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]  from_network_bridge_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]  from_network_bridge_tkeep,
   input  logic [AXIS_TDEST_WIDTH-1:0] from_network_bridge_tid,
   input  logic [AXIS_TDEST_WIDTH-1:0] from_network_bridge_tdest,
   input  logic [AXIS_TUSER_WIDTH-1:0] from_network_bridge_tuser,
   input  logic                        from_network_bridge_tlast,
   output logic [NUM_CHANNELS-1:0]     to_rpn_tvalid,
   input  logic [NUM_CHANNELS-1:0]     to_rpn_tready,
   output logic [AXIS_DATA_WIDTH-1:0]  to_rpn_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]  to_rpn_tkeep,
   output logic [AXIS_TDEST_WIDTH-1:0] to_rpn_tid,
   output logic [AXIS_TDEST_WIDTH-1:0] to_rpn_tdest,
   output logic [AXIS_TUSER_WIDTH-1:0] to_rpn_tuser,
   output logic                        to_rpn_tlast,
   output logic [31:0]                 o_drop_count,
   output logic                        o_in_packet
);

   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // FSM state register; kept as a named signal so checkers can bind to it.
   state_t                      state;
   logic                        rdy_en;
   logic [CH_W-1:0]             route_q;
   logic [NUM_CHANNELS-1:0]     vld_q;
   logic [AXIS_DATA_WIDTH-1:0]  data_q;
   logic [AXIS_KEEP_WIDTH-1:0]  keep_q;
   logic [AXIS_TDEST_WIDTH-1:0] id_q;
   logic [AXIS_TDEST_WIDTH-1:0] dest_q;
   logic [AXIS_TUSER_WIDTH-1:0] user_q;
   logic                        last_q;
   logic [31:0]                 drop_cnt_q;

   logic [MSG_TYPE_WIDTH-1:0]   msg_type;
   logic                        hit;
   logic [CH_W-1:0]             hit_ch;
   logic                        unload;
   logic                        accept;
   logic                        load;
   logic [CH_W-1:0]             load_ch;
   logic [NUM_CHANNELS-1:0]     load_onehot;
   logic                        first_drop;

   assign msg_type = from_network_bridge_tdata[MSG_TYPE_OFFSET +: MSG_TYPE_WIDTH];

   // Type match: scan high to low so the lowest matching channel wins.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (((msg_type ^ CH_MATCH_VALUE[k*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH]) &
              CH_MATCH_MASK[k*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH]) == '0) begin
            hit    = 1'b1;
            hit_ch = CH_W'(k);
         end
      end
   end

   // Only the selected channel's ready can drain the slice, since vld_q is one-hot.
   assign unload = |(vld_q & to_rpn_tready);
   // rdy_en keeps tready low during reset and for the first edge after it.
   assign from_network_bridge_tready = rdy_en & ((state == ST_DROP) | ~(|vld_q) | unload);
   assign accept = from_network_bridge_tvalid & from_network_bridge_tready;

   // Decide whether an accepted beat loads the slice and for which channel.
   always_comb begin
      load       = 1'b0;
      load_ch    = route_q;
      first_drop = 1'b0;
      if (accept) begin
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  load    = 1'b1;
                  load_ch = hit_ch;
               end else if (DROP_UNMATCHED == 0) begin
                  load    = 1'b1;
                  load_ch = CH_W'(DEFAULT_CHANNEL);
               end else begin
                  first_drop = 1'b1;
               end
            end
            ST_FWD:  load = 1'b1;
            default: load = 1'b0;
         endcase
      end
   end

   // One-hot valid pattern for the channel being loaded.
   always_comb begin
      load_onehot = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         load_onehot[k] = (load_ch == CH_W'(k));
      end
   end

   // Packet FSM: lock the route on the first beat, release on the tlast beat.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state   <= ST_IDLE;
         route_q <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            case (state)
               ST_IDLE: begin
                  route_q <= load_ch;
                  if (!from_network_bridge_tlast) begin
                     state <= first_drop ? ST_DROP : ST_FWD;
                  end
               end
               default: begin
                  if (from_network_bridge_tlast) begin
                     state <= ST_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Saturating count of dropped packets, bumped on each dropped first beat.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         drop_cnt_q <= '0;
      end else if (first_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   // Output slice: load and unload in the same cycle keep full throughput.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
         keep_q <= '0;
         id_q   <= '0;
         dest_q <= '0;
         user_q <= '0;
         last_q <= 1'b0;
      end else if (load) begin
         vld_q  <= load_onehot;
         data_q <= from_network_bridge_tdata;
         keep_q <= from_network_bridge_tkeep;
         id_q   <= from_network_bridge_tid;
         dest_q <= from_network_bridge_tdest;
         user_q <= from_network_bridge_tuser;
         last_q <= from_network_bridge_tlast;
      end else if (unload) begin
         vld_q <= '0;
      end
   end

   assign to_rpn_tvalid = vld_q;
   assign to_rpn_tdata  = data_q;
   assign to_rpn_tkeep  = keep_q;
   assign to_rpn_tid    = id_q;
   assign to_rpn_tdest  = dest_q;
   assign to_rpn_tuser  = user_q;
   assign to_rpn_tlast  = last_q;
   assign o_drop_count  = drop_cnt_q;
   assign o_in_packet   = (state != ST_IDLE);

endmodule

// File: tb/tb_rpn_axis_type_router.sv
// Bench for rpn_axis_type_router: a dropping instance carries most traffic,
// a second instance routes unmatched packets to channel 3.
module tb_rpn_axis_type_router;

   localparam int DW    = 64;
   localparam int KW    = 8;
   localparam int TW    = 8;
   localparam int UW    = 16;
   localparam int NCH   = 4;
   localparam int EXP_W = NCH + 1 + UW + TW + TW + KW + DW;

   localparam logic [31:0] TB_VAL  = {8'h40, 8'h20, 8'h10, 8'h00};
   localparam logic [31:0] TB_MASK = {8'hF0, 8'hE0, 8'hF0, 8'hF0};

   // ---------------- clock / reset ----------------
   logic i_clk;
   logic i_ap_rst_n;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // ---------------- DUT signals ----------------
   logic           nb_tvalid;
   logic           nb_tready;
   logic [DW-1:0]  nb_tdata;
   logic [KW-1:0]  nb_tkeep;
   logic [TW-1:0]  nb_tid;
   logic [TW-1:0]  nb_tdest;
   logic [UW-1:0]  nb_tuser;
   logic           nb_tlast;
   logic [NCH-1:0] rpn_tvalid;
   logic [NCH-1:0] rpn_tready;
   logic [DW-1:0]  rpn_tdata;
   logic [KW-1:0]  rpn_tkeep;
   logic [TW-1:0]  rpn_tid;
   logic [TW-1:0]  rpn_tdest;
   logic [UW-1:0]  rpn_tuser;
   logic           rpn_tlast;
   logic [31:0]    drop_count;
   logic           in_packet;

   logic           b_tvalid;
   logic           b_tready;
   logic [NCH-1:0] b_rpn_tvalid;
   logic [NCH-1:0] b_rpn_tready;
   logic [DW-1:0]  b_rpn_tdata;
   logic [KW-1:0]  b_rpn_tkeep;
   logic [TW-1:0]  b_rpn_tid;
   logic [TW-1:0]  b_rpn_tdest;
   logic [UW-1:0]  b_rpn_tuser;
   logic           b_rpn_tlast;
   logic [31:0]    b_drop_count;
   logic           b_in_packet;

   rpn_axis_type_router #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TDEST_WIDTH(TW),
      .AXIS_TUSER_WIDTH(UW), .NUM_CHANNELS(NCH),
      .DROP_UNMATCHED(1), .DEFAULT_CHANNEL(0)
   ) dut (
      .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n),
      .from_network_bridge_tvalid(nb_tvalid), .from_network_bridge_tready(nb_tready),
      .from_network_bridge_tdata(nb_tdata), .from_network_bridge_tkeep(nb_tkeep),
      .from_network_bridge_tid(nb_tid), .from_network_bridge_tdest(nb_tdest),
      .from_network_bridge_tuser(nb_tuser), .from_network_bridge_tlast(nb_tlast),
      .to_rpn_tvalid(rpn_tvalid), .to_rpn_tready(rpn_tready),
      .to_rpn_tdata(rpn_tdata), .to_rpn_tkeep(rpn_tkeep), .to_rpn_tid(rpn_tid),
      .to_rpn_tdest(rpn_tdest), .to_rpn_tuser(rpn_tuser), .to_rpn_tlast(rpn_tlast),
      .o_drop_count(drop_count), .o_in_packet(in_packet)
   );

   rpn_axis_type_router #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TDEST_WIDTH(TW),
      .AXIS_TUSER_WIDTH(UW), .NUM_CHANNELS(NCH),
      .DROP_UNMATCHED(0), .DEFAULT_CHANNEL(3)
   ) dut_dflt (
      .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n),
      .from_network_bridge_tvalid(b_tvalid), .from_network_bridge_tready(b_tready),
      .from_network_bridge_tdata(nb_tdata), .from_network_bridge_tkeep(nb_tkeep),
      .from_network_bridge_tid(nb_tid), .from_network_bridge_tdest(nb_tdest),
      .from_network_bridge_tuser(nb_tuser), .from_network_bridge_tlast(nb_tlast),
      .to_rpn_tvalid(b_rpn_tvalid), .to_rpn_tready(b_rpn_tready),
      .to_rpn_tdata(b_rpn_tdata), .to_rpn_tkeep(b_rpn_tkeep), .to_rpn_tid(b_rpn_tid),
      .to_rpn_tdest(b_rpn_tdest), .to_rpn_tuser(b_rpn_tuser), .to_rpn_tlast(b_rpn_tlast),
      .o_drop_count(b_drop_count), .o_in_packet(b_in_packet)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference routing: first channel whose masked bits agree with the type.
   function automatic int ref_chan(input logic [7:0] mtype, input bit drop_unm, input int dflt);
      logic [31:0] v;
      logic [31:0] m;
      v = TB_VAL;
      m = TB_MASK;
      for (int k = 0; k < NCH; k++) begin
         if ((mtype & m[k*8 +: 8]) == (v[k*8 +: 8] & m[k*8 +: 8])) return k;
      end
      return drop_unm ? -1 : dflt;
   endfunction

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               xfer_cyc_q[$];
   int               cyc = 0;
   bit               prev_stall = 0;
   logic [EXP_W-1:0] prev_snap;
   logic [EXP_W-1:0] got_w;
   logic [EXP_W-1:0] exp_w;

   always @(negedge i_clk) begin
      if (!i_ap_rst_n) begin
         prev_stall = 0;
      end else begin
         cyc++;
         got_w = {rpn_tvalid, rpn_tlast, rpn_tuser, rpn_tdest, rpn_tid, rpn_tkeep, rpn_tdata};
         if (rpn_tvalid != '0) begin
            check_eq("tvalid_onehot", 128'($countones(rpn_tvalid)), 128'd1);
         end
         if (prev_stall) begin
            check_eq("hold_stable", 128'(got_w), 128'(prev_snap));
         end
         if ((rpn_tvalid & rpn_tready) != '0) begin
            xfer_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               check_eq("spurious_beat", 128'(exp_q.size()), 128'd1);
            end else begin
               exp_w = exp_q.pop_front();
               check_eq("out_beat", 128'(got_w), 128'(exp_w));
            end
            prev_stall = 0;
         end else begin
            prev_stall = (rpn_tvalid != '0);
         end
         prev_snap = got_w;
      end
   end

   // ---------------- driver tasks ----------------
   int            stalls = 0;
   logic [DW-1:0] last_data;

   task automatic send_beat(input logic [7:0] mtype, input logic last, input int ch);
      logic [DW-1:0]  d;
      logic [NCH-1:0] oh;
      bit             ok;
      d        = {$urandom, $urandom};
      d[7:0]   = mtype;
      nb_tdata = d;
      nb_tkeep = KW'($urandom_range(0, 255));
      nb_tid   = TW'($urandom_range(0, 255));
      nb_tdest = TW'($urandom_range(0, 255));
      nb_tuser = UW'($urandom_range(0, 65535));
      nb_tlast = last;
      nb_tvalid = 1'b1;
      ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge i_clk);
         if (nb_tready) begin
            ok = 1;
            break;
         end
         stalls++;
      end
      if (ok) begin
         if (ch >= 0) begin
            oh = NCH'(1) << ch;
            exp_q.push_back({oh, last, nb_tuser, nb_tdest, nb_tid, nb_tkeep, d});
         end
         last_data = d;
         @(posedge i_clk);
         #1;
      end else begin
         check_eq("accept_timeout", 128'(nb_tready), 128'd1);
      end
      nb_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 50; n++) begin
         if (exp_q.size() == 0) break;
         @(posedge i_clk);
         #1;
      end
      check_eq("drain", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ch;
      logic [7:0] b2b_types[4];
      b2b_types = '{8'h01, 8'h11, 8'h21, 8'h41};

      i_ap_rst_n   = 1'b0;
      nb_tvalid    = 1'b0;
      b_tvalid     = 1'b0;
      nb_tdata     = '0;
      nb_tkeep     = '0;
      nb_tid       = '0;
      nb_tdest     = '0;
      nb_tuser     = '0;
      nb_tlast     = 1'b0;
      rpn_tready   = '1;
      b_rpn_tready = '1;

      // reset state
      #12;
      check_eq("rst_tvalid", 128'(rpn_tvalid), 128'd0);
      check_eq("rst_tdata", 128'(rpn_tdata), 128'd0);
      check_eq("rst_tready", 128'(nb_tready), 128'd0);
      check_eq("rst_drop", 128'(drop_count), 128'd0);
      check_eq("rst_in_pkt", 128'(in_packet), 128'd0);
      @(negedge i_clk);
      i_ap_rst_n = 1'b1;
      #1;
      check_eq("rel_tready_low", 128'(nb_tready), 128'd0);
      tick(1);
      check_eq("rel_tready_high", 128'(nb_tready), 128'd1);

      // single beat, type 0x05, only channel 0 ready
      rpn_tready = 4'b0001;
      send_beat(8'h05, 1'b1, ref_chan(8'h05, 1, 0));
      check_eq("t1_tvalid", 128'(rpn_tvalid), 128'h1);
      check_eq("t1_tdata", 128'(rpn_tdata), 128'(last_data));
      check_eq("t1_drop", 128'(drop_count), 128'd0);
      wait_drain();

      // type 0x35 waits on channel 2 while other channels are ready
      rpn_tready = 4'b1011;
      send_beat(8'h35, 1'b1, ref_chan(8'h35, 1, 0));
      tick(3);
      check_eq("t2_pending", 128'(exp_q.size()), 128'd1);
      check_eq("t2_tvalid", 128'(rpn_tvalid), 128'h4);
      check_eq("t2_tdata", 128'(rpn_tdata), 128'(last_data));
      rpn_tready = 4'b0100;
      wait_drain();
      rpn_tready = '1;

      // 4-beat packet: route fixed by first-beat type 0x12
      ch = ref_chan(8'h12, 1, 0);
      send_beat(8'h12, 1'b0, ch);
      check_eq("t3_in_pkt_b1", 128'(in_packet), 128'd1);
      send_beat(8'h45, 1'b0, ch);
      send_beat(8'h45, 1'b0, ch);
      check_eq("t3_in_pkt_b3", 128'(in_packet), 128'd1);
      send_beat(8'h45, 1'b1, ch);
      check_eq("t3_in_pkt_end", 128'(in_packet), 128'd0);
      wait_drain();

      // unmatched 0x90, 3 beats, dropped and counted once
      stalls = 0;
      ch = ref_chan(8'h90, 1, 0);
      send_beat(8'h90, 1'b0, ch);
      check_eq("t4_drop_b1", 128'(drop_count), 128'd1);
      check_eq("t4_in_pkt", 128'(in_packet), 128'd1);
      send_beat(8'h05, 1'b0, ch);
      send_beat(8'h05, 1'b1, ch);
      check_eq("t4_drop_end", 128'(drop_count), 128'd1);
      check_eq("t4_tvalid", 128'(rpn_tvalid), 128'd0);
      check_eq("t4_stalls", 128'(stalls), 128'd0);

      // default-route instance sends 0x90 to channel 3
      nb_tdata  = {$urandom, $urandom};
      nb_tdata[7:0] = 8'h90;
      nb_tlast  = 1'b1;
      b_tvalid  = 1'b1;
      @(negedge i_clk);
      check_eq("t5_tready", 128'(b_tready), 128'd1);
      @(posedge i_clk);
      #1;
      b_tvalid = 1'b0;
      check_eq("t5_tvalid", 128'(b_rpn_tvalid), 128'(NCH'(1) << ref_chan(8'h90, 0, 3)));
      check_eq("t5_tdata", 128'(b_rpn_tdata), 128'(nb_tdata));
      check_eq("t5_drop", 128'(b_drop_count), 128'd0);
      tick(1);
      check_eq("t5_taken", 128'(b_rpn_tvalid), 128'd0);

      // back-to-back single beats to all four channels
      stalls = 0;
      xfer_cyc_q.delete();
      foreach (b2b_types[i]) send_beat(b2b_types[i], 1'b1, ref_chan(b2b_types[i], 1, 0));
      wait_drain();
      check_eq("t6_stalls", 128'(stalls), 128'd0);
      check_eq("t6_xfers", 128'(xfer_cyc_q.size()), 128'd4);
      if (xfer_cyc_q.size() == 4) begin
         check_eq("t6_span", 128'(xfer_cyc_q[3] - xfer_cyc_q[0]), 128'd3);
      end

      // reset at beat 2 of a 4-beat packet
      send_beat(8'h05, 1'b0, ref_chan(8'h05, 1, 0));
      nb_tdata[7:0] = 8'h45;
      nb_tlast  = 1'b0;
      nb_tvalid = 1'b1;
      #1;
      i_ap_rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_eq("t7_tvalid", 128'(rpn_tvalid), 128'd0);
      check_eq("t7_tdata", 128'(rpn_tdata), 128'd0);
      check_eq("t7_tuser", 128'(rpn_tuser), 128'd0);
      check_eq("t7_drop", 128'(drop_count), 128'd0);
      check_eq("t7_in_pkt", 128'(in_packet), 128'd0);
      check_eq("t7_tready", 128'(nb_tready), 128'd0);
      nb_tvalid = 1'b0;
      repeat (2) @(negedge i_clk);
      i_ap_rst_n = 1'b1;
      tick(1);
      send_beat(8'h11, 1'b1, ref_chan(8'h11, 1, 0));
      check_eq("t7_new_route", 128'(rpn_tvalid), 128'h2);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
